dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, data-memory word-address width (2048 words).
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter CNT_W, default 16, width of the contention counter.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cpu_req / cpu_we  input  1 / 1  CPU load/store request and write-enable; held stable until cpu_ack.
REQ-007 cpu_addr / cpu_wdata  input  ADDR_W / DATA_W  CPU word address and store data.
REQ-008 cpu_rdata / cpu_ack / cpu_stall  output  DATA_W / 1 / 1  load data, completion pulse, pipeline stall.
REQ-009 dbg_req / dbg_we / dbg_addr / dbg_wdata  input  1 / 1 / ADDR_W / DATA_W  debug-loader port; same rules as CPU port.
REQ-010 dbg_rdata / dbg_ack  output  DATA_W / 1  debug read data and completion pulse.
REQ-011 mem_addr / mem_wdata / mem_we / mem_re  output  ADDR_W / DATA_W / 1 / 1  shared single-port memory drive.
REQ-012 mem_rdata  input  DATA_W  memory asynchronous read data.
REQ-013 conflict_cnt  output  CNT_W  saturating count of contention cycles.

Function
REQ-014 FSM states IDLE, ACC_CPU, ACC_DBG, RESP; one transaction in flight at a time.
REQ-015 IDLE: any pending req -> ACC_<winner> next cycle; none -> stay IDLE.
REQ-016 ACC_x: mem_addr/mem_wdata/mem_we/mem_re driven from winner's inputs for exactly one cycle; mem_re = ~we, mem_we = we; otherwise mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
REQ-017 ACC_x: mem_rdata captured into x_rdata register at end of cycle (reads only); x_rdata holds until next read by x.
REQ-018 RESP: x_ack high exactly one cycle; x then may drop or present a new req the following cycle.
REQ-019 RESP arbitrates only the other requester: its req pending -> ACC_other, else IDLE; the just-acked requester is ignored in RESP.
REQ-020 Latency: req sampled in IDLE cycle N -> memory access cycle N+1 -> ack cycle N+2; back-to-back service of alternate requesters every 2 cycles.
REQ-021 Default arbitration fixed priority: CPU wins when both request in IDLE.
REQ-022 cpu_stall = cpu_req & ~cpu_ack, combinational.
REQ-023 conflict_cnt increments each cycle a requester has req high and is not the one being granted/served while the other holds the resource or wins; saturates at all-ones.
REQ-024 Write-then-read same address by different requesters: read returns the written value (writes complete in ACC cycle before any later ACC).

Reset
REQ-025 rst in any state: next state IDLE; no ack issued for the aborted transaction.
REQ-026 During and after reset cycle: cpu_ack=0, dbg_ack=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, dbg_rdata=0, conflict_cnt=0.
REQ-027 Round-robin pointer (when compiled in) resets to "last granted = DBG", so CPU wins first tie.

Configuration
REQ-028 Macro DMEM_ARB_RR_EN defined: ties in IDLE go to the requester not granted most recently; pointer updates on entry to ACC_x.
REQ-029 DMEM_ARB_RR_EN undefined: fixed priority per REQ-021, no pointer register.

Structure
REQ-030 Package dmem_arb_pkg holds state enum (IDLE, ACC_CPU, ACC_DBG, RESP), requester-id type (REQ_CPU=0, REQ_DBG=1), default widths.
REQ-031 One sub-module dmem_arb_pick: combinational winner select from two reqs, last-grant pointer, exclude mask.

Verification
REQ-032 CPU read addr 5 (mem[5]=0xDEADBEEF), idle dbg -> mem_re at N+1, cpu_ack and cpu_rdata=0xDEADBEEF at N+2, cpu_stall high N..N+1.
REQ-033 Both req in same cycle, fixed priority: CPU acked N+2, DBG acked N+4; conflict_cnt=3.
REQ-034 DMEM_ARB_RR_EN, both hold continuous reqs 8 transactions: grants alternate CPU,DBG,CPU,..., first CPU.
REQ-035 DBG write addr 7 = 0x12345678, then CPU read addr 7 -> cpu_rdata=0x12345678.
REQ-036 rst asserted in ACC_CPU cycle of a write -> no cpu_ack, mem_we=0 in following cycle, state IDLE, conflict_cnt=0.
REQ-037 Force conflict for 2^CNT_W+5 cycles -> conflict_cnt saturates at all-ones.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 11;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC_CPU = 2'd1,
    ACC_DBG = 2'd2,
    RESP    = 2'd3
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU port, debug-loader port and shared memory bus of the data-memory arbiter.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

  // Requesters and memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arb_pick.sv
// Two-way combinational winner select with last-grant tie break and exclude mask.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  input  logic [1:0] excl,
  output logic       valid,
  output req_id_t    winner
);
  logic [1:0] eff;

  always_comb begin
    eff    = req & ~excl;
    valid  = |eff;
    winner = REQ_CPU;
    case (eff)
      2'b10:   winner = REQ_DBG;
      2'b11:   winner = (last == REQ_CPU) ? REQ_DBG : REQ_CPU;
      default: winner = REQ_CPU;
    endcase
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU and debug-loader access to a single-port data memory.
// Define DMEM_ARB_RR_EN for round-robin tie breaking (default: CPU priority).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  dmem_arbiter_if.slave    bus,
  output logic [CNT_W-1:0] conflict_cnt
);
  state_t            state_q, state_d;
  req_id_t           cur_q, cur_d;
  req_id_t           last_grant;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        excl;
  logic              pick_valid;
  req_id_t           pick_id;
  logic              contend;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_we, acc_re, cpu_ack, dbg_ack;

  // In RESP the requester just acknowledged is masked out of arbitration.
  assign excl = (state_q != RESP)  ? 2'b00 :
                (cur_q == REQ_CPU) ? 2'b01 : 2'b10;

  dmem_arb_pick u_pick (
    .req    ({bus.dbg_req, bus.cpu_req}),
    .last   (last_grant),
    .excl   (excl),
    .valid  (pick_valid),
    .winner (pick_id)
  );

`ifdef DMEM_ARB_RR_EN
  req_id_t last_q;
  always_ff @(posedge clk) begin
    if (rst)
      last_q <= REQ_DBG;
    else if ((state_q == IDLE || state_q == RESP) && pick_valid)
      last_q <= pick_id;
  end
  assign last_grant = last_q;
`else
  assign last_grant = REQ_DBG;
`endif

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (pick_valid) begin
          state_d = (pick_id == REQ_CPU) ? ACC_CPU : ACC_DBG;
          cur_d   = pick_id;
        end else begin
          state_d = IDLE;
        end
      end
      ACC_CPU, ACC_DBG: state_d = RESP;
    endcase
  end

  // Outputs are forced quiet while rst is high so an aborted write never lands.
  always_comb begin
    acc_addr  = '0;
    acc_wdata = '0;
    acc_we    = 1'b0;
    acc_re    = 1'b0;
    cpu_ack   = 1'b0;
    dbg_ack   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ACC_CPU: begin
          acc_addr  = bus.cpu_addr;
          acc_wdata = bus.cpu_wdata;
          acc_we    = bus.cpu_we;
          acc_re    = ~bus.cpu_we;
        end
        ACC_DBG: begin
          acc_addr  = bus.dbg_addr;
          acc_wdata = bus.dbg_wdata;
          acc_we    = bus.dbg_we;
          acc_re    = ~bus.dbg_we;
        end
        RESP: begin
          cpu_ack = (cur_q == REQ_CPU);
          dbg_ack = (cur_q == REQ_DBG);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    contend = 1'b0;
    unique case (state_q)
      IDLE:    contend = bus.cpu_req & bus.dbg_req;
      ACC_CPU: contend = bus.dbg_req;
      ACC_DBG: contend = bus.cpu_req;
      RESP:    contend = (cur_q == REQ_CPU) ? bus.dbg_req : bus.cpu_req;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= REQ_CPU;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      if (state_q == ACC_CPU && !bus.cpu_we) cpu_rdata_q <= bus.mem_rdata;
      if (state_q == ACC_DBG && !bus.dbg_we) dbg_rdata_q <= bus.mem_rdata;
      if (contend && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.mem_addr  = acc_addr;
  assign bus.mem_wdata = acc_wdata;
  assign bus.mem_we    = acc_we;
  assign bus.mem_re    = acc_re;
  assign bus.cpu_ack   = cpu_ack;
  assign bus.dbg_ack   = dbg_ack;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ack;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign conflict_cnt  = cnt_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: transaction-level model predicts grant order,
// timing, memory traffic, read data and contention count.
module tb_dmem_arbiter;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } tx_t;
  typedef struct { longint cyc; bit dbg; bit rd; logic [DW-1:0] val; } ack_t;
  typedef struct { longint cyc; tx_t t; } macc_t;
  typedef struct { string name; logic [63:0] act; logic [63:0] exp; } chk_t;

  logic clk = 1'b0;
  logic rst;
  logic [CW-1:0] conflict_cnt;
  longint cyc;
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  ack_t  aq[$];
  macc_t mq[$];
  chk_t  chkq[$];
  tx_t   cq[$], dq[$];

  logic [DW-1:0] ref_mem [int];
  bit            last_dbg;
  longint        cnt_model;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  bit            written [0:(1<<AW)-1];

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == AW'(5)) return 32'hDEADBEEF;
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  assign bus.mem_rdata = written[bus.mem_addr] ? mem[bus.mem_addr] : init_val(bus.mem_addr);
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr]     <= bus.mem_wdata;
      written[bus.mem_addr] <= 1'b1;
    end
  end

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  function automatic void expect_eq(input string n, input logic [63:0] a, input logic [63:0] e);
    chkq.push_back('{n, a, e});
  endfunction

  task automatic cmp(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // Monitor: pops expected acks / memory accesses and drains queued direct checks.
  always @(negedge clk) begin
    ack_t  e;
    macc_t m;
    chk_t  c;
    bit    exp_c, exp_d;
    if (mon_en) begin
      while (aq.size() > 0 && aq[0].cyc < cyc) begin
        e = aq.pop_front();
        cmp(e.dbg ? "dbg_ack_missing" : "cpu_ack_missing", 64'd0, 64'd1);
      end
      exp_c = 1'b0;
      exp_d = 1'b0;
      if (aq.size() > 0 && aq[0].cyc == cyc) begin
        e = aq.pop_front();
        exp_c = !e.dbg;
        exp_d = e.dbg;
        if (e.rd && !e.dbg) cmp("cpu_rdata", 64'(bus.cpu_rdata), 64'(e.val));
        if (e.rd &&  e.dbg) cmp("dbg_rdata", 64'(bus.dbg_rdata), 64'(e.val));
      end
      cmp("cpu_ack", 64'(bus.cpu_ack), 64'(exp_c));
      cmp("dbg_ack", 64'(bus.dbg_ack), 64'(exp_d));
      cmp("cpu_stall", 64'(bus.cpu_stall), 64'(bus.cpu_req & ~exp_c));
      while (mq.size() > 0 && mq[0].cyc < cyc) begin
        void'(mq.pop_front());
        cmp("mem_access_missing", 64'd0, 64'd1);
      end
      if (mq.size() > 0 && mq[0].cyc == cyc) begin
        m = mq.pop_front();
        cmp("mem_we", 64'(bus.mem_we), 64'(m.t.we));
        cmp("mem_re", 64'(bus.mem_re), 64'(!m.t.we));
        cmp("mem_addr", 64'(bus.mem_addr), 64'(m.t.addr));
        cmp("mem_wdata", 64'(bus.mem_wdata), 64'(m.t.wdata));
      end else begin
        cmp("mem_bus_idle", 64'({bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata}), 64'd0);
      end
    end
    while (chkq.size() > 0) begin
      c = chkq.pop_front();
      cmp(c.name, c.act, c.exp);
    end
  end

  task automatic apply_cpu(input tx_t t);
    bus.cpu_req = 1'b1; bus.cpu_we = t.we; bus.cpu_addr = t.addr; bus.cpu_wdata = t.wdata;
  endtask

  task automatic apply_dbg(input tx_t t);
    bus.dbg_req = 1'b1; bus.dbg_we = t.we; bus.dbg_addr = t.addr; bus.dbg_wdata = t.wdata;
  endtask

  function automatic tx_t rand_tx();
    tx_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = AW'($urandom_range(0, 15));
    t.wdata = $urandom;
    return t;
  endfunction

  // Issues cq/dq back-to-back (each requester renews right after its ack).
  // Both-active sequences must have equal lengths.
  task automatic run_seq();
    int nc = cq.size();
    int nd = dq.size();
    int ic = 0, id = 0, dic = 0, did = 0, guard = 0;
    longint t;
    bit who_dbg, ca, da;
    tx_t tx;
    who_dbg = (nc > 0 && nd > 0) ? (RR ? !last_dbg : 1'b0) : (nd > 0);
    t = cyc + 2;
    for (int i = 0; i < nc + nd; i++) begin
      if (who_dbg) begin tx = dq[id]; id++; end
      else         begin tx = cq[ic]; ic++; end
      mq.push_back('{t - 1, tx});
      aq.push_back('{t, who_dbg, !tx.we, ref_rd(tx.addr)});
      if (tx.we) ref_mem[int'(tx.addr)] = tx.wdata;
      last_dbg = who_dbg;
      if (who_dbg ? (ic < nc) : (id < nd)) begin who_dbg = !who_dbg; t += 2; end
      else t += 3;
    end
    if (nc > 0 && nd > 0) cnt_model += 4 * nc - 1;
    if (cnt_model > (64'd1 << CW) - 1) cnt_model = (64'd1 << CW) - 1;

    if (nc > 0) begin apply_cpu(cq[0]); dic = 1; end
    if (nd > 0) begin apply_dbg(dq[0]); did = 1; end
    while ((bus.cpu_req || bus.dbg_req) && guard < 40) begin
      @(negedge clk);
      ca = bus.cpu_ack;
      da = bus.dbg_ack;
      @(posedge clk); #1;
      if (ca) begin
        if (dic < nc) begin apply_cpu(cq[dic]); dic++; end else bus.cpu_req = 1'b0;
      end
      if (da) begin
        if (did < nd) begin apply_dbg(dq[did]); did++; end else bus.dbg_req = 1'b0;
      end
      guard++;
    end
    if (guard >= 40) begin
      expect_eq("seq_timeout", 64'd1, 64'd0);
      bus.cpu_req = 1'b0;
      bus.dbg_req = 1'b0;
    end
    expect_eq("conflict_cnt", 64'(conflict_cnt), 64'(cnt_model));
    cq.delete();
    dq.delete();
  endtask

  initial begin
    tx_t t;
    int  mode, n;
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    last_dbg  = 1'b1;
    cnt_model = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_eq("rst_outputs", 64'({bus.cpu_ack, bus.dbg_ack, bus.mem_we, bus.mem_re,
                                  bus.mem_addr, bus.mem_wdata}), 64'd0);
    expect_eq("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
    expect_eq("rst_dbg_rdata", 64'(bus.dbg_rdata), 64'd0);
    expect_eq("rst_conflict_cnt", 64'(conflict_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // CPU load from address 5 with debug port idle
    cq.push_back('{1'b0, AW'(5), 32'h0});
    run_seq();
    // Simultaneous requests
    cq.push_back(rand_tx());
    dq.push_back(rand_tx());
    run_seq();
    // Debug store then CPU load of the same word
    dq.push_back('{1'b1, AW'(7), 32'h12345678});
    run_seq();
    cq.push_back('{1'b0, AW'(7), 32'h0});
    run_seq();
    // Continuous requests from both: grants alternate
    for (int i = 0; i < 4; i++) begin cq.push_back(rand_tx()); dq.push_back(rand_tx()); end
    run_seq();

    for (int r = 0; r < 40; r++) begin
      mode = $urandom_range(0, 2);
      n    = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        if (mode != 1) cq.push_back(rand_tx());
        if (mode != 0) dq.push_back(rand_tx());
      end
      run_seq();
    end

    // Reset during the access cycle of a CPU store
    mon_en = 1'b0;
    t = '{1'b1, AW'(9), 32'hCAFEF00D};
    apply_cpu(t);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    expect_eq("rst_acc_mem_we", 64'(bus.mem_we), 64'd0);
    expect_eq("rst_acc_cpu_ack", 64'(bus.cpu_ack), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    expect_eq("post_rst_ack", 64'({bus.cpu_ack, bus.dbg_ack}), 64'd0);
    expect_eq("post_rst_mem_we", 64'(bus.mem_we), 64'd0);
    expect_eq("post_rst_conflict_cnt", 64'(conflict_cnt), 64'd0);
    expect_eq("post_rst_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
    expect_eq("post_rst_dbg_rdata", 64'(bus.dbg_rdata), 64'd0);
    last_dbg  = 1'b1;
    cnt_model = 0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    // Aborted store must not have reached memory; a tie now goes to the CPU
    cq.push_back('{1'b0, AW'(9), 32'h0});
    dq.push_back(rand_tx());
    run_seq();

    // Sustained contention saturates the counter
    mon_en = 1'b0;
    bus.cpu_we = 1'b0; bus.dbg_we = 1'b0;
    bus.cpu_req = 1'b1; bus.dbg_req = 1'b1;
    repeat ((1 << CW) + 5) @(posedge clk);
    #1;
    expect_eq("conflict_sat", 64'(conflict_cnt), 64'((64'd1 << CW) - 1));
    repeat (3) @(posedge clk);
    #1;
    expect_eq("conflict_sat_hold", 64'(conflict_cnt), 64'((64'd1 << CW) - 1));
    bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
